// File: rtl/conv3x3_stream_ctrl_pkg.sv
// rtl/conv3x3_stream_ctrl_pkg.sv - shared types and helpers for the 3x3 convolution stream sequencer
package conv3x3_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [7:0] row0;
    logic [7:0] row1;
    logic [7:0] row2;
  } row_col_t;

  // Number of full 3x3 windows in a w x h frame
  function automatic int unsigned expected_results(input int unsigned w, input int unsigned h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - single-port line buffer, synchronous read-before-write
// old_data exposes the word at addr before this cycle's write, used to cascade buffers.
module conv_line_buffer #(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    old_data,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:DEPTH-1];

  assign old_data = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv3x3_stream_ctrl.sv
// rtl/conv3x3_stream_ctrl.sv - feeds 3-row pixel columns to the 3x3 convolution and checks its result count
module conv3x3_stream_ctrl
  import conv3x3_stream_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = 11,
  parameter int YW    = 10,
  parameter int CW    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_pix_valid,
  output logic       o_pix_ready,
  input  logic [7:0] i_pix,
  output logic [7:0] o_row0,
  output logic [7:0] o_row1,
  output logic [7:0] o_row2,
  output logic       o_conv_valid,
  output logic       o_conv_done,
  input  logic       i_conv_valid,
  input  logic       i_conv_img_done,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_count_err
);

  localparam int              AW      = $clog2(IMG_W);
  localparam logic [XW-1:0]   X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]   Y_LAST  = YW'(IMG_H - 1);
  localparam logic [CW-1:0]   EXP_CNT = CW'(expected_results(IMG_W, IMG_H));

  ctrl_state_t   state, state_next;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    run;
  logic [CW-1:0] res_cnt, res_cnt_next;
  logic          pix_ready, start_frame, frame_end, count_en;
  logic          hs, last_pix, win_ok;
  logic          hs_d, conv_valid_q, conv_done_q, count_err;
  logic [7:0]    pix_q, lb1_q, lb2_q, lb1_old, lb2_old_unused;
  row_col_t      col;

  assign hs       = i_pix_valid && pix_ready;
  assign last_pix = (x == X_LAST) && (y == Y_LAST);
  // The convolution shifts every clock, so all three columns must arrive back to back
  assign win_ok   = (x >= XW'(2)) && (y >= YW'(2)) && (run == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pix_ready   = 1'b0;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    count_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          start_frame = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        pix_ready = 1'b1;
        count_en  = 1'b1;
        if (i_pix_valid && last_pix) state_next = DRAIN;
      end
      DRAIN: begin
        count_en = 1'b1;
        if (i_conv_img_done) begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x            <= '0;
      y            <= '0;
      run          <= '0;
      hs_d         <= 1'b0;
      pix_q        <= '0;
      conv_valid_q <= 1'b0;
      conv_done_q  <= 1'b0;
    end else begin
      hs_d         <= hs;
      conv_valid_q <= hs && win_ok;
      conv_done_q  <= hs && win_ok && last_pix;
      if (hs) pix_q <= i_pix;
      if (start_frame) begin
        x   <= '0;
        y   <= '0;
        run <= '0;
      end else if (hs) begin
        if (x == X_LAST) begin
          x   <= '0;
          y   <= y + YW'(1);
          run <= '0;
        end else begin
          x <= x + XW'(1);
          if (run != 2'd2) run <= run + 2'd1;
        end
      end else begin
        run <= '0;
      end
    end
  end

  // A result arriving with the image-done strobe is counted before the compare
  assign res_cnt_next = (count_en && i_conv_valid) ? res_cnt + CW'(1) : res_cnt;

  always_ff @(posedge clk) begin
    if (reset || start_frame) begin
      res_cnt   <= '0;
      count_err <= 1'b0;
    end else begin
      res_cnt <= res_cnt_next;
      if (frame_end && (res_cnt_next != EXP_CNT)) count_err <= 1'b1;
    end
  end

  conv_line_buffer #(.DEPTH(IMG_W), .AW(AW)) lb1 (
    .clk      (clk),
    .en       (hs),
    .addr     (x[AW-1:0]),
    .wdata    (i_pix),
    .old_data (lb1_old),
    .rdata    (lb1_q)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .AW(AW)) lb2 (
    .clk      (clk),
    .en       (hs),
    .addr     (x[AW-1:0]),
    .wdata    (lb1_old),
    .old_data (lb2_old_unused),
    .rdata    (lb2_q)
  );

  always_comb begin
    col = '0;
    if (hs_d) begin
      col.row0 = pix_q;
      col.row1 = lb1_q;
      col.row2 = lb2_q;
    end
  end

  assign o_row0       = col.row0;
  assign o_row1       = col.row1;
  assign o_row2       = col.row2;
  assign o_pix_ready  = pix_ready;
  assign o_conv_valid = conv_valid_q;
  assign o_conv_done  = conv_done_q;
  assign o_busy       = (state != IDLE);
  assign o_frame_done = frame_end;
  assign o_count_err  = count_err;

endmodule
